apb_master: RTL and testbench

Single-outstanding APB3 requester that converts a simple valid/ready command stream into APB transfers toward the register-file slave. It sits directly upstream of the APB slave, drives PSEL/PENABLE/PADDR/PWRITE/PWDATA, and waits on PREADY. It captures PRDATA and PSLVERR and returns a response beat. It also bounds slave wait states with a timeout so a hung slave cannot stall the command source.

---
 rtl/apb_pkg.sv | 37 +++
 rtl/apb_timeout_ctr.sv | 54 +++++
 rtl/apb_master.sv | 147 ++++++++++++++
 tb/tb_apb_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and defaults for the APB requester and the
//               slave-side checker.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Default bus geometry
    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    // Requester transfer phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Response beat returned to the command source
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

    // Read data to return: writes and aborted transfers carry zero
    function automatic logic [APB_DATA_W-1:0] apb_rsp_data(
        input logic                  is_write,
        input logic [APB_DATA_W-1:0] prdata
    );
        return is_write ? '0 : prdata;
    endfunction

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : apb_timeout_ctr
// Description : Wait-state counter for the APB ACCESS phase. Flags expiry
//               when the count reaches TIMEOUT-1; tied off for TIMEOUT=0.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT > 0) begin : g_count
            localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Next count: clear wins, then saturating increment at the limit
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (enable_i && (cnt_q != C_LIMIT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Count register
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired_o = (cnt_q == C_LIMIT);
        end else begin : g_disabled
            logic w_unused;
            assign w_unused  = &{1'b0, clk_i, rst_ni, clear_i, enable_i};
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule : apb_timeout_ctr
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding APB3 requester. Turns a valid/ready
//               command stream into SETUP/ACCESS transfers, captures the
//               slave response and aborts hung transfers after TIMEOUT
//               ACCESS cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    // Command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // Response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB requester side
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e        state_q;
    logic              cmd_ready_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              w_tmo_clear;
    logic              w_tmo_enable;
    logic              w_tmo_expired;

    // The counter restarts while in SETUP so it reads zero on ACCESS entry,
    // and only advances on ACCESS cycles the slave stretches.
    assign w_tmo_clear  = (state_q == SETUP);
    assign w_tmo_enable = (state_q == ACCESS) && !PREADY;

    apb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .clear_i   (w_tmo_clear),
        .enable_i  (w_tmo_enable),
        .expired_o (w_tmo_expired)
    );

    // Transfer FSM with all bus and stream outputs registered
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q    <= cmd_write;
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_wdata;
                        psel_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY on the limit cycle still counts as a completion
                    if (PREADY) begin
                        rsp_err_q   <= PSLVERR;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (w_tmo_expired) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule : apb_master
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master
// Description : Directed self-checking bench for apb_master (TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              PCLK;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    apb_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command at a negedge; it is accepted at the next posedge (edge N)
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        check_eq("cmd_ready_before_issue", {63'd0, cmd_ready}, 64'd1);
        @(posedge PCLK);
        #1;
        // Scramble the command inputs so any failure to latch shows on the bus
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wd;
    endtask

    // Run one transfer. ready_at = ACCESS cycle (1-based) with PREADY=1, 0 = never.
    // Returns with the bench sitting on the negedge where rsp_valid is first seen.
    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        input int ready_at, input logic [DATA_W-1:0] rd, input logic err,
                        output int n_access, output int n_setup, output int lat);
        n_access = 0;
        n_setup  = 0;
        lat      = 0;
        issue(wr, addr, wd);
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            lat++;
            if (rsp_valid) break;
            if (PSEL) begin
                check_eq("paddr_stable",  {56'd0, PADDR}, {56'd0, addr});
                check_eq("pwdata_stable", {32'd0, PWDATA}, {32'd0, wd});
                check_eq("pwrite_stable", {63'd0, PWRITE}, {63'd0, wr});
                check_eq("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
            end
            if (PSEL && PENABLE) begin
                n_access++;
                PREADY  = (n_access == ready_at);
                PRDATA  = (n_access == ready_at) ? rd : 32'hBAD0_0000 | n_access;
                PSLVERR = (n_access == ready_at) ? err : 1'b1;
            end else begin
                if (PSEL) n_setup++;
                PREADY  = 1'b0;
                PSLVERR = 1'b1;
                PRDATA  = 32'hFFFF_FFFF;
            end
        end
        check_eq("rsp_within_budget", {63'd0, rsp_valid}, 64'd1);
        // Slave keeps driving junk afterwards; it must be ignored
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'h5555_AAAA;
    endtask

    // Hold rsp_ready low for n cycles, checking the parked state, then consume
    task automatic hold_and_consume(input int n, input logic [DATA_W-1:0] exp_rd, input logic exp_err);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            check_eq("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check_eq("hold_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rd});
            check_eq("hold_rsp_err",   {63'd0, rsp_err}, {63'd0, exp_err});
            check_eq("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            check_eq("hold_psel",      {63'd0, PSEL}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge PCLK);
        #1;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        @(negedge PCLK);
        check_eq("consumed_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("consumed_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    endtask

    int na, ns, lt;

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        repeat (2) @(negedge PCLK);
        check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check_eq("rst_psel",      {63'd0, PSEL}, 64'd0);
        check_eq("rst_penable",   {63'd0, PENABLE}, 64'd0);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_outputs",   {PADDR, PWDATA, PWRITE, rsp_err, rsp_rdata[21:0]}, 64'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Zero-wait write
        xfer(1'b1, 8'h04, 32'hDEADBEEF, 1, 32'h0, 1'b0, na, ns, lt);
        check_eq("w0_access_cycles", 64'(na), 64'd1);
        check_eq("w0_setup_cycles",  64'(ns), 64'd1);
        check_eq("w0_latency",       64'(lt), 64'd3);
        check_eq("w0_rsp_err",   {63'd0, rsp_err}, 64'd0);
        check_eq("w0_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check_eq("w0_bus_idle",  {62'd0, PSEL, PENABLE}, 64'd0);
        hold_and_consume(0, 32'h0, 1'b0);

        // Read with 3 wait states
        xfer(1'b0, 8'h08, 32'h0, 4, 32'h12345678, 1'b0, na, ns, lt);
        check_eq("r3_access_cycles", 64'(na), 64'd4);
        check_eq("r3_latency",       64'(lt), 64'd6);
        check_eq("r3_rsp_err",   {63'd0, rsp_err}, 64'd0);
        check_eq("r3_rsp_rdata", {32'd0, rsp_rdata}, 64'h12345678);
        hold_and_consume(1, 32'h12345678, 1'b0);

        // Slave error on a write
        xfer(1'b1, 8'h0C, 32'h0BADF00D, 1, 32'h77777777, 1'b1, na, ns, lt);
        check_eq("err_latency",   64'(lt), 64'd3);
        check_eq("err_rsp_err",   {63'd0, rsp_err}, 64'd1);
        check_eq("err_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check_eq("err_bus_idle",  {62'd0, PSEL, PENABLE}, 64'd0);
        hold_and_consume(1, 32'h0, 1'b1);

        // Timeout: PREADY never rises
        xfer(1'b0, 8'h10, 32'h0, 0, 32'h0, 1'b0, na, ns, lt);
        check_eq("tmo_access_cycles", 64'(na), 64'd16);
        check_eq("tmo_latency",       64'(lt), 64'd18);
        check_eq("tmo_rsp_err",   {63'd0, rsp_err}, 64'd1);
        check_eq("tmo_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check_eq("tmo_psel",      {63'd0, PSEL}, 64'd0);
        hold_and_consume(1, 32'h0, 1'b1);

        // PREADY on the 16th ACCESS cycle completes normally
        xfer(1'b0, 8'h14, 32'h0, 16, 32'hCAFEF00D, 1'b0, na, ns, lt);
        check_eq("lim_access_cycles", 64'(na), 64'd16);
        check_eq("lim_latency",       64'(lt), 64'd18);
        check_eq("lim_rsp_err",   {63'd0, rsp_err}, 64'd0);
        check_eq("lim_rsp_rdata", {32'd0, rsp_rdata}, 64'hCAFEF00D);
        hold_and_consume(1, 32'hCAFEF00D, 1'b0);

        // Backpressure: response parked for 10 cycles
        xfer(1'b0, 8'h18, 32'h0, 2, 32'hA5A55A5A, 1'b0, na, ns, lt);
        check_eq("bp_latency", 64'(lt), 64'd4);
        hold_and_consume(10, 32'hA5A55A5A, 1'b0);

        // Asynchronous reset in the middle of ACCESS
        issue(1'b1, 8'h1C, 32'h13579BDF);
        @(negedge PCLK);
        @(negedge PCLK);
        check_eq("rst_mid_in_access", {62'd0, PSEL, PENABLE}, 64'd3);
        PREADY = 1'b0;
        #2 PRESETn = 1'b0;
        #1;
        check_eq("arst_psel",      {63'd0, PSEL}, 64'd0);
        check_eq("arst_penable",   {63'd0, PENABLE}, 64'd0);
        check_eq("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("arst_paddr",     {56'd0, PADDR}, 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check_eq("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check_eq("post_rst_bus_idle",  {62'd0, PSEL, PENABLE}, 64'd0);

        // Reset while a response is pending discards it
        xfer(1'b0, 8'h20, 32'h0, 1, 32'h600DCAFE, 1'b0, na, ns, lt);
        check_eq("pend_rsp_rdata", {32'd0, rsp_rdata}, 64'h600DCAFE);
        #1 PRESETn = 1'b0;
        #1;
        check_eq("pend_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("pend_rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        @(negedge PCLK);
        check_eq("pend_post_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Recovery after reset: one more zero-wait read
        xfer(1'b0, 8'h24, 32'h0, 1, 32'h0F0F0F0F, 1'b0, na, ns, lt);
        check_eq("rec_latency",   64'(lt), 64'd3);
        check_eq("rec_rsp_rdata", {32'd0, rsp_rdata}, 64'h0F0F0F0F);
        hold_and_consume(0, 32'h0F0F0F0F, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_apb_master
`default_nettype wire
